fir_coef_reader_mac: RTL and testbench

//  Sequential single-MAC FIR engine; the reading end of the 16-bit coefficient ROM (7-bit address, 1-cycle registered read).

---
 rtl/fir_coef_reader_mac_if.sv | 26 ++
 rtl/fir_coef_reader_mac.sv | 132 +++++++++++++
 tb/tb_fir_coef_reader_mac.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_reader_mac_if.sv
// Handshake and coefficient-ROM bundle for the single-MAC FIR engine.
// The engine side uses the slave modport; the sample source, sink and ROM use master.
interface fir_coef_reader_mac_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ADDR_W = 7
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic [ADDR_W-1:0]        coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, coef_data, out_ready,
      input  in_ready, coef_addr, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, coef_data, out_ready,
      output in_ready, coef_addr, out_valid, out_data
   );
endinterface

// File: rtl/fir_coef_reader_mac.sv
// Sequential single-MAC FIR engine. Takes one sample per handshake, walks the
// coefficient ROM taps 0..NUM_TAPS-1, accumulates h[k]*x[n-k] at full precision
// and emits one rounded, saturated sample per input.
module fir_coef_reader_mac #(
   parameter int NUM_TAPS  = 61,
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int ADDR_W    = 7,
   parameter int ACC_W     = 40,
   parameter int OUT_SHIFT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fir_coef_reader_mac_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TAPS - 1);
   // Modular add of NUM_TAPS; stays correct even when NUM_TAPS == 2**IDX_W
   localparam logic [IDX_W-1:0] NT   = IDX_W'(NUM_TAPS);
   localparam logic signed [ACC_W-1:0] ONE  = ACC_W'(1);
   localparam logic signed [ACC_W-1:0] RND  = ONE <<< (OUT_SHIFT - 1);
   localparam logic signed [ACC_W-1:0] SMAX = (ONE <<< (DATA_W - 1)) - ONE;
   localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ONE;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   state_t                   state;
   logic signed [DATA_W-1:0] sbuf [NUM_TAPS];
   logic [IDX_W-1:0]         wr_ptr;
   logic [IDX_W-1:0]         cur;
   logic [IDX_W-1:0]         tap;
   logic [IDX_W-1:0]         rd_d;
   logic                     acc_en;
   logic                     drain_ph;
   logic signed [ACC_W-1:0]  acc;

   logic [IDX_W-1:0]         rd;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_x;
   logic signed [ACC_W-1:0]  acc_rnd;
   logic signed [ACC_W-1:0]  sh;
   logic signed [DATA_W-1:0] sat_val;

   // History index for the current tap, walking backwards with wrap 0 -> NUM_TAPS-1
   assign rd      = (cur >= tap) ? (cur - tap) : (cur + NT - tap);
   assign prod    = bus.coef_data * sbuf[rd_d];
   assign prod_x  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign acc_rnd = acc + RND;
   assign sh      = acc_rnd >>> OUT_SHIFT;

   // Clamp the rounded accumulator into the output range
   always_comb begin
      sat_val = sh[DATA_W-1:0];
      if (sh > SMAX)
         sat_val = SMAX[DATA_W-1:0];
      else if (sh < SMIN)
         sat_val = SMIN[DATA_W-1:0];
   end

   // Control FSM, sample buffer, accumulator and all registered outputs.
   // coef_data and buf[rd_d] for a tap line up in the cycle after that tap's
   // MAC cycle, so acc_en trails the MAC state by one cycle. DRAIN takes two
   // cycles: the first absorbs the last product, the second rounds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.coef_addr <= '0;
         acc           <= '0;
         wr_ptr        <= '0;
         cur           <= '0;
         tap           <= '0;
         rd_d          <= '0;
         acc_en        <= 1'b0;
         drain_ph      <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) sbuf[i] <= '0;
      end else begin
         acc_en <= (state == MAC);
         if (state == IDLE && bus.in_valid && bus.in_ready)
            acc <= '0;
         else if (acc_en)
            acc <= acc + prod_x;

         case (state)
            IDLE: begin
               bus.coef_addr <= '0;
               if (bus.in_valid && bus.in_ready) begin
                  sbuf[wr_ptr] <= bus.in_data;
                  cur          <= wr_ptr;
                  tap          <= '0;
                  bus.in_ready <= 1'b0;
                  state        <= MAC;
               end else begin
                  bus.in_ready <= 1'b1;
               end
            end
            MAC: begin
               rd_d <= rd;
               tap  <= tap + 1'b1;
               if (tap == LAST) begin
                  bus.coef_addr <= '0;
                  drain_ph      <= 1'b0;
                  state         <= DRAIN;
               end else begin
                  bus.coef_addr <= ADDR_W'(tap + 1'b1);
               end
            end
            DRAIN: begin
               if (!drain_ph) begin
                  drain_ph <= 1'b1;
               end else begin
                  bus.out_data  <= sat_val;
                  bus.out_valid <= 1'b1;
                  wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                  state         <= OUT;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_coef_reader_mac.sv
// Directed bench for fir_coef_reader_mac: reset, impulse response, timing,
// saturation, backpressure, mid-run reset and a long random run across the
// history wrap, with a small ROM model and golden FIR model.
module tb_fir_coef_reader_mac;
   localparam int NT = 61;
   localparam int HALF [31] = '{28, 26, 20, 6, -15, -40, -62, -74, -68, -38, 15,
                               82, 146, 186, 180, 115, -9, -172, -336, -451, -466,
                               -339, -48, 393, 945, 1565, 2197, 2781, 3350, 4300, 4911};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   bad_addr = 0;
   int   lat, addr_err;
   logic rdy_after, ov_after;
   logic rom_sat = 1'b0;

   logic signed [15:0] tab  [128];
   logic signed [15:0] hist [NT];
   int                 wp;

   fir_coef_reader_mac_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(7)) bus ();

   fir_coef_reader_mac dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Coefficient ROM with one-cycle registered read
   always @(posedge clk) begin
      if (rst_n && bus.coef_addr >= 7'd61) bad_addr++;
      bus.coef_data <= rom_sat ? 16'sh7FFF : tab[bus.coef_addr];
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(input logic signed [15:0] x);
      longint acc, r, c;
      int idx;
      hist[wp] = x;
      acc = 0;
      for (int k = 0; k < NT; k++) begin
         idx = (wp - k + NT) % NT;
         c   = rom_sat ? 32767 : longint'(tab[k]);
         acc += c * longint'(hist[idx]);
      end
      r = (acc + 16384) >>> 15;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      wp = (wp + 1) % NT;
      return int'(r);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NT; i++) hist[i] = '0;
      wp = 0;
   endtask

   task automatic start_s(input logic signed [15:0] x);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("start_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic finish_s(input int exp, input string tag);
      int n;
      n = 0;
      addr_err = 0;
      if (bus.coef_addr != 7'd0) addr_err++;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (n <= 60 && int'(bus.coef_addr) != n) addr_err++;
      end
      lat = n;
      if (n >= 200) chk({tag, "_timeout"}, 0, 1);
      chk(tag, bus.out_data, exp);
      if (bus.out_ready) begin
         @(posedge clk); #1;
         rdy_after = bus.in_ready;
         ov_after  = bus.out_valid;
      end
   endtask

   task automatic run(input logic signed [15:0] x, input int exp, input string tag);
      start_s(x);
      finish_s(exp, tag);
   endtask

   task automatic runm(input logic signed [15:0] x, input string tag);
      int e;
      e = model(x);
      run(x, e, tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e, errs;
      logic signed [15:0] held, x;
      for (int i = 0; i < 128; i++) tab[i] = '0;
      for (int k = 0; k <= 30; k++) begin
         tab[k]      = 16'(HALF[k]);
         tab[60 - k] = 16'(HALF[k]);
      end
      model_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_coef_addr", bus.coef_addr, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      @(negedge clk) rst_n = 1'b1;

      // Impulse response, plus timing on the first sample
      for (int n = 0; n < 65; n++) begin
         x = (n == 0) ? 16'sh7FFF : 16'sh0000;
         void'(model(x));
         run(x, (n < NT) ? int'(tab[n]) : 0, $sformatf("imp_%0d", n));
         if (n == 0) begin
            chk("lat_out_valid", lat, 63);
            chk("coef_addr_seq", addr_err, 0);
            chk("in_ready_back", rdy_after, 1);
            chk("out_valid_drop", ov_after, 0);
         end
      end

      // Backpressure: output held, in_valid pulses ignored
      bus.out_ready = 1'b0;
      e = model(16'sd1234);
      start_s(16'sd1234);
      finish_s(e, "bp_out");
      held = bus.out_data;
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 16'sh5555;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (!bus.out_valid || bus.out_data != held || bus.in_ready) errs++;
      end
      chk("bp_hold", errs, 0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", bus.out_valid, 0);
      runm(-16'sd500, "bp_next");

      // Saturation with an all-0x7FFF ROM
      rom_sat = 1'b1;
      for (int i = 0; i < NT; i++) begin
         if (i == NT - 1) begin
            void'(model(16'sd32767));
            run(16'sd32767, 32767, "sat_pos_full");
         end else runm(16'sd32767, "sat_pos");
      end
      for (int i = 0; i < NT; i++) begin
         if (i == NT - 1) begin
            void'(model(-16'sd32768));
            run(-16'sd32768, -32768, "sat_neg_full");
         end else runm(-16'sd32768, "sat_neg");
      end

      // Reset in the middle of MAC: outputs clear at once, history discarded
      start_s(16'sd9999);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_data", bus.out_data, 0);
      chk("midrst_coef_addr", bus.coef_addr, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      rom_sat = 1'b0;
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      void'(model(16'sh7FFF));
      run(16'sh7FFF, 28, "midrst_first");

      // Random run across the history wrap
      for (int i = 0; i < 130; i++) begin
         x = 16'($urandom);
         runm(x, $sformatf("rnd_%0d", i));
      end

      chk("addr_range", bad_addr, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
